// File: rtl/prio_arbiter.sv
// Registered N-request priority arbiter: fixed-priority or round-robin selection,
// grant held until the owner acknowledges or withdraws its request.
module prio_arbiter #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         ack,
    output logic         valid,
    output logic [N-1:0] grant,
    output logic [W-1:0] code
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [W-1:0]   ptr;
    logic [W-1:0]   ptr_nx;
    logic [W-1:0]   g;
    logic [W-1:0]   g_nx;
    logic           rr;
    logic           rr_nx;
    logic           valid_nx;
    logic [N-1:0]   grant_nx;
    logic [W-1:0]   code_nx;
    logic [W-1:0]   win;
    logic [W-1:0]   cand;
    logic           req_g;
    logic           done;

    // grant is one-hot on g, so this picks out req[g] without a variable index
    assign req_g = |(req & grant);
    assign done  = ack || !req_g;

    // Winner search; in round-robin the offset-0 candidate (ptr itself) is written last
    always_comb begin
        win  = '0;
        cand = '0;
        if (!mode) begin
            for (int k = 0; k < int'(N); k++) begin
                if (|(req & (N'(1) << k))) win = W'(k);
            end
        end else begin
            for (int k = int'(N) - 1; k >= 0; k--) begin
                cand = W'((int'(ptr) + int'(N) - k) % int'(N));
                if (|(req & (N'(1) << cand))) win = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= W'(N - 1);
            g     <= '0;
            rr    <= 1'b0;
            valid <= 1'b0;
            grant <= '0;
            code  <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            g     <= g_nx;
            rr    <= rr_nx;
            valid <= valid_nx;
            grant <= grant_nx;
            code  <= code_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|req) state_nx = GRANT;
            GRANT:   if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping registers
    always_comb begin
        valid_nx = valid;
        grant_nx = grant;
        code_nx  = code;
        g_nx     = g;
        rr_nx    = rr;
        ptr_nx   = ptr;
        case (state)
            IDLE: begin
                if (|req) begin
                    valid_nx = 1'b1;
                    grant_nx = N'(1) << win;
                    code_nx  = win + W'(1);
                    g_nx     = win;
                    rr_nx    = mode;
                end
            end
            GRANT: begin
                if (done) begin
                    valid_nx = 1'b0;
                    grant_nx = '0;
                    code_nx  = '0;
                    if (ack && rr) ptr_nx = (g == '0) ? W'(N - 1) : g - W'(1);
                end
            end
            default: begin
                valid_nx = 1'b0;
                grant_nx = '0;
                code_nx  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_prio_arbiter.sv
// Bench for prio_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_prio_arbiter;

    localparam int unsigned N = 8;
    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic         mode;
    logic         ack;
    logic         valid;
    logic [N-1:0] grant;
    logic [W-1:0] code;

    int passed = 0;
    int total  = 0;

    // Behavioural model state
    bit m_busy = 1'b0;
    int m_g    = 0;
    bit m_rr   = 1'b0;
    int m_ptr  = N - 1;

    prio_arbiter #(.N(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .mode  (mode),
        .ack   (ack),
        .valid (valid),
        .grant (grant),
        .code  (code)
    );

    always #5 clk = ~clk;

    function automatic bit bit_of(input logic [N-1:0] r, input int i);
        return ((r >> i) & N'(1)) != '0;
    endfunction

    function automatic int model_winner(input logic [N-1:0] r, input bit m, input int p);
        if (!m) begin
            for (int i = N - 1; i >= 0; i--) if (bit_of(r, i)) return i;
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                int j;
                j = (p - k + int'(N)) % int'(N);
                if (bit_of(r, j)) return j;
            end
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input bit m, input bit a, input bit rs);
        if (rs) begin
            m_busy = 1'b0;
            m_ptr  = N - 1;
        end else if (!m_busy) begin
            if (r != '0) begin
                m_g    = model_winner(r, m, m_ptr);
                m_busy = 1'b1;
                m_rr   = m;
            end
        end else if (a) begin
            m_busy = 1'b0;
            if (m_rr) m_ptr = (m_g == 0) ? N - 1 : m_g - 1;
        end else if (!bit_of(r, m_g)) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic compare_model(input int cyc);
        logic         ev;
        logic [N-1:0] eg;
        logic [W-1:0] ec;
        ev = m_busy;
        eg = m_busy ? (N'(1) << m_g) : '0;
        ec = m_busy ? W'(m_g + 1) : '0;
        total++;
        if (valid === ev && grant === eg && code === ec) passed++;
        else $display("FAIL model cycle %0d: got valid=%b grant=%b code=%0d, expected valid=%b grant=%b code=%0d",
                      cyc, valid, grant, code, ev, eg, ec);
    endtask

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    int cyc = 0;

    // Apply inputs, advance one edge, step the model, compare on the falling edge
    task automatic step(input logic [N-1:0] r, input bit m, input bit a, input bit rs);
        req = r; mode = m; ack = a; reset = rs;
        @(posedge clk);
        model_step(r, m, a, rs);
        @(negedge clk);
        cyc++;
        compare_model(cyc);
    endtask

    initial begin
        logic [N-1:0] r;
        bit m;
        bit a;
        bit rs;

        req = '0; mode = 1'b0; ack = 1'b0; reset = 1'b1;

        // Reset with all requests high
        step(8'hFF, 1'b1, 1'b0, 1'b1);
        step(8'hFF, 1'b1, 1'b0, 1'b1);
        check_lit("reset_valid", 32'(valid), 32'd0);
        check_lit("reset_grant", 32'(grant), 32'd0);
        check_lit("reset_code",  32'(code),  32'd0);
        step(8'hFF, 1'b1, 1'b0, 1'b0);
        check_lit("first_rr_code",  32'(code),  32'd8);
        check_lit("first_rr_grant", 32'(grant), 32'h80);

        // Round-robin rotation: 7,6,...,1 then back to 8
        for (int i = 1; i <= 8; i++) begin
            step(8'hFF, 1'b1, 1'b1, 1'b0);
            check_lit($sformatf("rr_gap_%0d", i), 32'(valid), 32'd0);
            step(8'hFF, 1'b1, 1'b0, 1'b0);
            check_lit($sformatf("rr_code_%0d", i), 32'(code), (i < 8) ? 32'(8 - i) : 32'd8);
        end
        step(8'hFF, 1'b1, 1'b1, 1'b0);

        // Fixed priority
        step(8'h26, 1'b0, 1'b0, 1'b0);
        check_lit("fixed_grant", 32'(grant), 32'h20);
        check_lit("fixed_code",  32'(code),  32'd6);
        step(8'h26, 1'b0, 1'b1, 1'b0);
        check_lit("fixed_gap", 32'(valid), 32'd0);
        step(8'h26, 1'b0, 1'b0, 1'b0);
        check_lit("fixed_regrant", 32'(grant), 32'h20);
        step(8'h00, 1'b0, 1'b0, 1'b0);

        // Withdrawal leaves ptr alone
        step(8'h08, 1'b1, 1'b0, 1'b0);
        check_lit("wd_code", 32'(code), 32'd4);
        step(8'h00, 1'b1, 1'b0, 1'b0);
        check_lit("wd_released", 32'(valid), 32'd0);
        step(8'h09, 1'b1, 1'b0, 1'b0);
        check_lit("wd_regrant_code", 32'(code), 32'd4);
        step(8'h09, 1'b1, 1'b1, 1'b0);

        // No preemption, mode change ignored during grant
        step(8'h04, 1'b0, 1'b0, 1'b0);
        check_lit("np_code", 32'(code), 32'd3);
        step(8'h84, 1'b1, 1'b0, 1'b0);
        check_lit("np_hold_grant", 32'(grant), 32'h04);
        step(8'h84, 1'b0, 1'b0, 1'b0);
        check_lit("np_hold_code", 32'(code), 32'd3);
        step(8'h84, 1'b1, 1'b1, 1'b0);
        check_lit("np_release", 32'(valid), 32'd0);

        // Reset in the middle of a grant
        step(8'h20, 1'b0, 1'b0, 1'b0);
        check_lit("rm_code", 32'(code), 32'd6);
        step(8'h20, 1'b0, 1'b0, 1'b1);
        check_lit("rm_cleared", 32'(valid), 32'd0);
        step(8'hA0, 1'b1, 1'b0, 1'b0);
        check_lit("rm_next_code", 32'(code), 32'd8);
        step(8'h00, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with mostly sticky requests
        r = '0;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0:       r = N'($urandom);
                1:       r = '0;
                2:       r = '1;
                3, 4:    r = r ^ (N'(1) << $urandom_range(0, N - 1));
                default: r = r;
            endcase
            m  = ($urandom_range(0, 1) == 1);
            a  = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 149) == 0);
            step(r, m, a, rs);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
